// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control codes, main-decoder ALUOp encodings
// and R-type funct values used by the EX stage and the ALU.
package mips_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd12;
   localparam logic [3:0] ALU_NONE = 4'd15;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_AND   = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: main-decoder ALUOp plus funct field to the
// 4-bit ALU operation code. Unsupported R-type functs map to ALU_NONE.
module alu_ctrl_decode
   import mips_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_NONE;
      case (alu_op_i)
         ALUOP_ADD: alu_ctrl_o = ALU_ADD;
         ALUOP_SUB: alu_ctrl_o = ALU_SUB;
         ALUOP_AND: alu_ctrl_o = ALU_AND;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_ADD, FUNCT_ADDU: alu_ctrl_o = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: alu_ctrl_o = ALU_SUB;
               FUNCT_AND:             alu_ctrl_o = ALU_AND;
               FUNCT_OR:              alu_ctrl_o = ALU_OR;
               FUNCT_NOR:             alu_ctrl_o = ALU_NOR;
               default:               alu_ctrl_o = ALU_NONE;
            endcase
         end
         default: alu_ctrl_o = ALU_NONE;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, forwards
// MEM/WB results onto the operands, selects the immediate and flags load-use hazards.
module id_ex_operand_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [1:0]    id_alu_op,
   input  logic [5:0]    id_funct,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [AW-1:0] id_rs_addr,
   input  logic [AW-1:0] id_rt_addr,
   input  logic [AW-1:0] id_rd_addr,
   input  logic          id_alu_src,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic          id_branch,
   input  logic          mem_reg_write,
   input  logic [AW-1:0] mem_rd_addr,
   input  logic [DW-1:0] mem_alu_out,
   input  logic          wb_reg_write,
   input  logic [AW-1:0] wb_rd_addr,
   input  logic [DW-1:0] wb_data,
   output logic [3:0]    ex_ALUctrl,
   output logic [DW-1:0] ex_rs,
   output logic [DW-1:0] ex_rt,
   output logic [DW-1:0] ex_store_data,
   output logic [AW-1:0] ex_dest_addr,
   output logic          ex_valid,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg,
   output logic          ex_branch,
   output logic          load_use_hazard
);

   logic          valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q, alu_src_q;
   logic          valid_d, reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, branch_d, alu_src_d;
   logic [3:0]    alu_ctrl_q, alu_ctrl_d;
   logic [AW-1:0] dest_q, dest_d, rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
   logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic [3:0]    id_alu_ctrl;
   logic          take_bubble, take_capture;
   logic [DW-1:0] rs_fwd, rt_fwd;

   alu_ctrl_decode u_alu_ctrl_decode (
      .alu_op_i   (id_alu_op),
      .funct_i    (id_funct),
      .alu_ctrl_o (id_alu_ctrl)
   );

   assign load_use_hazard = valid_q & mem_read_q & (dest_q != '0) & id_valid &
                            ((id_rs_addr == dest_q) | (id_rt_addr == dest_q));

   // Flush beats stall; stall beats the hazard bubble; an invalid ID slot loads as a bubble.
   assign take_bubble  = flush | (~stall & (load_use_hazard | ~id_valid));
   assign take_capture = ~flush & ~stall & ~load_use_hazard & id_valid;

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      branch_d     = branch_q;
      alu_src_d    = alu_src_q;
      alu_ctrl_d   = alu_ctrl_q;
      dest_d       = dest_q;
      rs_addr_d    = rs_addr_q;
      rt_addr_d    = rt_addr_q;
      rs_data_d    = rs_data_q;
      rt_data_d    = rt_data_q;
      imm_d        = imm_q;
      if (take_bubble) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         branch_d     = 1'b0;
         alu_src_d    = 1'b0;
         alu_ctrl_d   = '0;
         dest_d       = '0;
         rs_addr_d    = '0;
         rt_addr_d    = '0;
         rs_data_d    = '0;
         rt_data_d    = '0;
         imm_d        = '0;
      end else if (take_capture) begin
         valid_d      = 1'b1;
         reg_write_d  = id_reg_write;
         mem_read_d   = id_mem_read;
         mem_write_d  = id_mem_write;
         mem_to_reg_d = id_mem_to_reg;
         branch_d     = id_branch;
         alu_src_d    = id_alu_src;
         alu_ctrl_d   = id_alu_ctrl;
         dest_d       = id_reg_dst ? id_rd_addr : id_rt_addr;
         rs_addr_d    = id_rs_addr;
         rt_addr_d    = id_rt_addr;
         rs_data_d    = id_rs_data;
         rt_data_d    = id_rt_data;
         imm_d        = id_imm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= '0;
         dest_q       <= '0;
         rs_addr_q    <= '0;
         rt_addr_q    <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         branch_q     <= branch_d;
         alu_src_q    <= alu_src_d;
         alu_ctrl_q   <= alu_ctrl_d;
         dest_q       <= dest_d;
         rs_addr_q    <= rs_addr_d;
         rt_addr_q    <= rt_addr_d;
         rs_data_q    <= rs_data_d;
         rt_data_q    <= rt_data_d;
         imm_q        <= imm_d;
      end
   end

   // MEM result is newer than WB, so it wins when both target the same register.
   always_comb begin
      rs_fwd = rs_data_q;
      if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr_q)) rs_fwd = mem_alu_out;
      else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr_q)) rs_fwd = wb_data;
      rt_fwd = rt_data_q;
      if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rt_addr_q)) rt_fwd = mem_alu_out;
      else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rt_addr_q)) rt_fwd = wb_data;
   end

   assign ex_ALUctrl    = alu_ctrl_q;
   assign ex_rs         = rs_fwd;
   assign ex_rt         = alu_src_q ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;
   assign ex_dest_addr  = dest_q;
   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_branch     = branch_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly upstream of the ALU and drives the ALU's ALUctrl, rs and rt inputs.
- Captures decoded instruction fields and decodes ALUOp/funct into the 4-bit ALU control code.
- Applies MEM/WB forwarding to the operands, selects the immediate, and detects load-use hazards.
- Supports pipeline stall, flush and bubble insertion.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold EX contents (downstream busy)
- flush  in  1  replace EX contents with bubble (branch taken)
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  main-decoder ALUOp
- id_funct  in  6  instruction funct field
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs_addr, id_rt_addr, id_rd_addr  in  AW  register numbers
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoder controls
- mem_reg_write  in  1  EX/MEM stage writes a register
- mem_rd_addr  in  AW  EX/MEM destination
- mem_alu_out  in  DW  EX/MEM result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd_addr  in  AW  MEM/WB destination
- wb_data  in  DW  MEM/WB write-back value
- ex_ALUctrl  out  4  to ALU ALUctrl
- ex_rs  out  DW  to ALU rs (forwarded A operand)
- ex_rt  out  DW  to ALU rt (B operand, immediate or forwarded rt)
- ex_store_data  out  DW  forwarded rt for stores
- ex_dest_addr  out  AW  registered destination
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered controls
- load_use_hazard  out  1  to PC/IF-ID: hold upstream this cycle

Behaviour:
- Reset (async, rst=1): all registered state 0, so ex_ALUctrl=0 and every control/valid output is 0. ex_rs, ex_rt and ex_store_data then evaluate from zeroed registers; forwarding is inactive because the stored addresses are 0.
- Register update priority at posedge clk: flush → bubble; else stall → hold all state; else load_use_hazard → bubble; else capture ID inputs.
- Bubble: ex_valid and all control bits 0, ALUctrl 0, addresses and data 0.
- Capture:
  - ex_dest_addr = id_reg_dst ? id_rd_addr : id_rt_addr.
  - If id_valid=0, capture as a bubble.
- ALUctrl decode, performed at capture:
  - ALUOp 00 → 2 (add).
  - ALUOp 01 → 6 (sub).
  - ALUOp 11 → 0 (and).
  - ALUOp 10, by funct: 100000/100001 → 2; 100010/100011 → 6; 100100 → 0; 100101 → 1; 100111 → 12.
  - Any other funct → 15 (ALU yields 0).
- Forwarding is combinational on the registered rs/rt addresses and data; each operand is handled independently.
  - Forward from MEM when mem_reg_write=1, mem_rd_addr≠0 and mem_rd_addr equals the stored address.
  - Otherwise forward from WB under the same rule using wb_reg_write, wb_rd_addr and wb_data.
  - Otherwise use the registered register-file data.
  - MEM has priority over WB when both match. Register 0 is never forwarded.
- ex_rt = stored alu_src ? stored imm : forwarded rt. ex_store_data = forwarded rt regardless of alu_src.
- load_use_hazard (combinational) = ex_valid & ex_mem_read & ex_dest_addr≠0 & id_valid & (id_rs_addr==ex_dest_addr | id_rt_addr==ex_dest_addr).
- Effect of load_use_hazard: a one-cycle bubble follows; upstream must hold ID on the same cycle.
- Stall with hazard: if stall=1 and load_use_hazard=1, hold wins and the hazard persists to the next cycle.
- Flush with stall: flush overrides stall.
- Zero-latency path: forwarded values reach ex_rs/ex_rt in the same cycle the MEM/WB inputs change.

Decomposition:
- Shared package mips_pkg:
  - ALU control codes: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_NOR=12, ALU_NONE=15.
  - ALUOp encodings.
  - funct constants.
- One sub-module alu_ctrl_decode: combinational ALUOp+funct → 4-bit code, reusable by the ALU testbench.
- Forwarding mux and hazard logic are inline.

Test Plan:
- Reset: assert rst mid-operation with ex_valid=1 → all control outputs 0 and ex_ALUctrl=0 immediately, without waiting for a clock edge.
- R-type decode: ALUOp=10 with funct 100010, 100111, 100101 and 101010 on successive cycles → ex_ALUctrl = 6, 12, 1, 15 one cycle later.
- Forwarding:
  - Stored rs=8, mem_rd=8 with 0x11, wb_rd=8 with 0x22 → ex_rs=0x11.
  - Drop mem_reg_write → ex_rs=0x22.
  - Stored rs=0, mem_rd=0 with 0x33 → ex_rs = register-file data.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x5 → ex_rt=0xFFFFFFFC and ex_store_data=0x5.
- Load-use: EX holds lw with dest 9 and ID reads rt=9 → load_use_hazard=1. Next edge: ex_valid=0, ex_reg_write=0. Following edge: the held instruction is captured.
- Stall/flush interplay:
  - stall=1 for 3 cycles → outputs unchanged.
  - stall=1 with flush=1 → bubble.
  - stall=1 with load_use_hazard=1 → hold; the hazard stays asserted.
